// File: rtl/pdpu_shift_pkg.sv
// Shared types and elaboration helpers for the PDPU pipelined shifter.
package pdpu_shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_e;

    // Levels grouped into each register stage; the last stage may take fewer.
    function automatic int levels_per_stage(input int shift_width, input int pipe_regs);
        return (shift_width + pipe_regs - 1) / pipe_regs;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational log-shifter level: shifts by 2**LEVEL when enabled and
// folds any bits dropped off the right end into the running sticky.
module shift_level
    import pdpu_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEVEL = 0
) (
    input  logic [WIDTH-1:0] operand,
    input  logic             enable,
    input  shift_op_e        op,
    input  logic             sticky_prev,
    output logic [WIDTH-1:0] result,
    output logic             sticky
);
    localparam int DIST = 2 ** LEVEL;

    logic fill;

    always_comb begin
        result = operand;
        sticky = sticky_prev;
        fill   = (op == SHIFT_SRA) ? operand[WIDTH-1] : 1'b0;
        if (enable) begin
            case (op)
                SHIFT_SLL: result = {operand[WIDTH-DIST-1:0], {DIST{1'b0}}};
                SHIFT_SRL, SHIFT_SRA: begin
                    result = {{DIST{fill}}, operand[WIDTH-1:DIST]};
                    sticky = sticky_prev | (|operand[DIST-1:0]);
                end
                SHIFT_ROR: result = {operand[DIST-1:0], operand[WIDTH-1:DIST]};
                default:   result = operand;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA/ROR log-shifter with sticky, tag passthrough and
// valid/ready backpressure; latency equals PIPE_REGS.
module pipelined_barrel_shifter
    import pdpu_shift_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SHIFT_WIDTH = $clog2(WIDTH),
    parameter int PIPE_REGS   = 2,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [WIDTH-1:0]       operand_i,
    input  logic [SHIFT_WIDTH-1:0] shift_amount_i,
    input  shift_op_e              op_i,
    input  logic [TAG_WIDTH-1:0]   tag_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [WIDTH-1:0]       result_o,
    output logic                   sticky_o,
    output logic [TAG_WIDTH-1:0]   tag_o
);
    localparam int LPS = levels_per_stage(SHIFT_WIDTH, PIPE_REGS);

    logic                   st_valid   [PIPE_REGS];
    logic [WIDTH-1:0]       st_data    [PIPE_REGS];
    logic [SHIFT_WIDTH-1:0] st_amt     [PIPE_REGS];
    shift_op_e              st_op      [PIPE_REGS];
    logic                   st_sticky  [PIPE_REGS];
    logic [TAG_WIDTH-1:0]   st_tag     [PIPE_REGS];

    logic                   nxt_valid  [PIPE_REGS];
    logic [WIDTH-1:0]       nxt_data   [PIPE_REGS];
    logic [SHIFT_WIDTH-1:0] nxt_amt    [PIPE_REGS];
    shift_op_e              nxt_op     [PIPE_REGS];
    logic                   nxt_sticky [PIPE_REGS];
    logic [TAG_WIDTH-1:0]   nxt_tag    [PIPE_REGS];

    logic                   adv        [PIPE_REGS];

    logic [WIDTH-1:0]       lvl_in         [SHIFT_WIDTH];
    logic [WIDTH-1:0]       lvl_out        [SHIFT_WIDTH];
    logic                   lvl_sticky_in  [SHIFT_WIDTH];
    logic                   lvl_sticky_out [SHIFT_WIDTH];
    logic [SHIFT_WIDTH-1:0] lvl_amt        [SHIFT_WIDTH];
    shift_op_e              lvl_op         [SHIFT_WIDTH];

    // A stage may advance if it, or any stage below it, holds a bubble.
    always_comb begin
        logic drain;
        drain = out_ready_i;
        for (int g = PIPE_REGS - 1; g >= 0; g--) begin
            drain  = drain | ~st_valid[g];
            adv[g] = drain;
        end
    end

    assign in_ready_o = adv[0] & ~flush_i;

    // Position p handles level SHIFT_WIDTH-1-p, so levels run MSB first.
    for (genvar p = 0; p < SHIFT_WIDTH; p++) begin : g_level
        localparam int LEVEL = SHIFT_WIDTH - 1 - p;
        if (p == 0) begin : g_src_in
            assign lvl_in[p]        = operand_i;
            assign lvl_sticky_in[p] = 1'b0;
            assign lvl_amt[p]       = shift_amount_i;
            assign lvl_op[p]        = op_i;
        end else if (p % LPS == 0) begin : g_src_reg
            assign lvl_in[p]        = st_data[p/LPS - 1];
            assign lvl_sticky_in[p] = st_sticky[p/LPS - 1];
            assign lvl_amt[p]       = st_amt[p/LPS - 1];
            assign lvl_op[p]        = st_op[p/LPS - 1];
        end else begin : g_src_chain
            assign lvl_in[p]        = lvl_out[p-1];
            assign lvl_sticky_in[p] = lvl_sticky_out[p-1];
            assign lvl_amt[p]       = lvl_amt[p-1];
            assign lvl_op[p]        = lvl_op[p-1];
        end

        shift_level #(
            .WIDTH (WIDTH),
            .LEVEL (LEVEL)
        ) u_level (
            .operand     (lvl_in[p]),
            .enable      (lvl_amt[p][LEVEL]),
            .op          (lvl_op[p]),
            .sticky_prev (lvl_sticky_in[p]),
            .result      (lvl_out[p]),
            .sticky      (lvl_sticky_out[p])
        );
    end

    for (genvar g = 0; g < PIPE_REGS; g++) begin : g_stage
        localparam int FIRST = g * LPS;
        localparam int LAST  = ((g + 1) * LPS < SHIFT_WIDTH) ? (g + 1) * LPS - 1 : SHIFT_WIDTH - 1;
        if (g == 0) begin : g_head
            assign nxt_valid[g] = in_valid_i & in_ready_o;
            assign nxt_amt[g]   = shift_amount_i;
            assign nxt_op[g]    = op_i;
            assign nxt_tag[g]   = tag_i;
        end else begin : g_body
            assign nxt_valid[g] = st_valid[g-1];
            assign nxt_amt[g]   = st_amt[g-1];
            assign nxt_op[g]    = st_op[g-1];
            assign nxt_tag[g]   = st_tag[g-1];
        end
        // Rounding up the group size can leave trailing stages with no levels.
        if (FIRST < SHIFT_WIDTH) begin : g_levels
            assign nxt_data[g]   = lvl_out[LAST];
            assign nxt_sticky[g] = lvl_sticky_out[LAST];
        end else begin : g_pass
            assign nxt_data[g]   = st_data[g-1];
            assign nxt_sticky[g] = st_sticky[g-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int g = 0; g < PIPE_REGS; g++) begin
                st_valid[g]  <= 1'b0;
                st_data[g]   <= '0;
                st_amt[g]    <= '0;
                st_op[g]     <= SHIFT_SLL;
                st_sticky[g] <= 1'b0;
                st_tag[g]    <= '0;
            end
        end else begin
            for (int g = 0; g < PIPE_REGS; g++) begin
                if (flush_i) begin
                    st_valid[g] <= 1'b0;
                end else if (adv[g]) begin
                    st_valid[g] <= nxt_valid[g];
                end
                // Payload only moves with a real operation; bubbles keep old data.
                if (adv[g] && nxt_valid[g] && !flush_i) begin
                    st_data[g]   <= nxt_data[g];
                    st_amt[g]    <= nxt_amt[g];
                    st_op[g]     <= nxt_op[g];
                    st_sticky[g] <= nxt_sticky[g];
                    st_tag[g]    <= nxt_tag[g];
                end
            end
        end
    end

    assign out_valid_o = st_valid[PIPE_REGS-1];
    assign result_o    = st_data[PIPE_REGS-1];
    assign sticky_o    = st_sticky[PIPE_REGS-1];
    assign tag_o       = st_tag[PIPE_REGS-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter: hand-computed vectors, a
// backpressured stream against a reference model, flush, reset and depth sweep.
`timescale 1ns/1ps
module tb_pipelined_barrel_shifter;
    import pdpu_shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand;
    logic [4:0]  amt;
    shift_op_e   op;
    logic [3:0]  tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        sticky;
    logic [3:0]  tag_out;

    logic        sw_valid;
    logic        sw_ready = 1'b1;
    logic        sw_in_ready  [3];
    logic        sw_out_valid [3];
    logic [31:0] sw_result    [3];
    logic        sw_sticky    [3];
    logic [3:0]  sw_tag       [3];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(
        .WIDTH     (32),
        .PIPE_REGS (2),
        .TAG_WIDTH (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .operand_i      (operand),
        .shift_amount_i (amt),
        .op_i           (op),
        .tag_i          (tag),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .result_o       (result),
        .sticky_o       (sticky),
        .tag_o          (tag_out)
    );

    // Depth sweep: instance i has PIPE_REGS = 2*i+1 (1, 3, 5).
    for (genvar i = 0; i < 3; i++) begin : g_sweep
        pipelined_barrel_shifter #(
            .WIDTH     (32),
            .PIPE_REGS (2 * i + 1),
            .TAG_WIDTH (4)
        ) u_sw (
            .clk_i          (clk),
            .rst_i          (rst),
            .flush_i        (flush),
            .in_valid_i     (sw_valid),
            .in_ready_o     (sw_in_ready[i]),
            .operand_i      (operand),
            .shift_amount_i (amt),
            .op_i           (op),
            .tag_i          (tag),
            .out_valid_o    (sw_out_valid[i]),
            .out_ready_i    (sw_ready),
            .result_o       (sw_result[i]),
            .sticky_o       (sw_sticky[i]),
            .tag_o          (sw_tag[i])
        );
    end

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] ref_shift(input logic [31:0] a, input logic [4:0] sh,
                                               input shift_op_e o);
        logic [31:0] r;
        logic        s;
        logic [31:0] mask;
        mask = (32'h1 << sh) - 32'h1;
        s    = 1'b0;
        case (o)
            SHIFT_SLL: r = a << sh;
            SHIFT_SRL: begin r = a >> sh; s = |(a & mask); end
            SHIFT_SRA: begin r = 32'($signed(a) >>> sh); s = |(a & mask); end
            default:   r = (a >> sh) | (a << (6'd32 - {1'b0, sh}));
        endcase
        return {s, r};
    endfunction

    task automatic issue_one(input string name, input shift_op_e o, input logic [31:0] a,
                             input logic [4:0] sh, input logic [3:0] tg,
                             input logic [31:0] exp_r, input logic exp_s);
        int lat;
        op = o; operand = a; amt = sh; tag = tg; in_valid = 1'b1;
        #1;
        check_eq({name, " in_ready"}, 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check_eq({name, " latency"}, 64'(lat), 64'(2));
        check_eq({name, " result"}, 64'(result), 64'(exp_r));
        check_eq({name, " sticky"}, 64'(sticky), 64'(exp_s));
        check_eq({name, " tag"}, 64'(tag_out), 64'(tg));
        tick();
    endtask

    task automatic sweep_one(input string name, input shift_op_e o, input logic [31:0] a,
                             input logic [4:0] sh, input logic [31:0] exp_r, input logic exp_s);
        int          lat [3];
        logic [31:0] r   [3];
        logic        s   [3];
        for (int i = 0; i < 3; i++) begin lat[i] = 0; r[i] = '0; s[i] = 1'b0; end
        op = o; operand = a; amt = sh; tag = 4'h9; sw_valid = 1'b1;
        tick();
        sw_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (lat[i] == 0 && sw_out_valid[i]) begin
                    lat[i] = c; r[i] = sw_result[i]; s[i] = sw_sticky[i];
                end
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("%s pr%0d latency", name, 2 * i + 1), 64'(lat[i]), 64'(2 * i + 1));
            check_eq($sformatf("%s pr%0d result", name, 2 * i + 1), 64'(r[i]), 64'(exp_r));
            check_eq($sformatf("%s pr%0d sticky", name, 2 * i + 1), 64'(s[i]), 64'(exp_s));
        end
    endtask

    task automatic run_stream();
        logic [31:0] v_a  [16];
        logic [4:0]  v_sh [16];
        shift_op_e   v_op [16];
        logic [36:0] exp_q [$];
        logic [36:0] e;
        logic [37:0] held;
        logic        stalled;
        int          sent, got, cyc;
        for (int i = 0; i < 16; i++) begin
            v_a[i]  = $urandom;
            v_sh[i] = 5'($urandom_range(0, 31));
            v_op[i] = shift_op_e'($urandom_range(0, 3));
        end
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
        while ((sent < 16 || got < 16) && cyc < 400) begin
            out_ready = ($urandom_range(0, 2) != 0);
            if (sent < 16) begin
                in_valid = 1'b1;
                operand  = v_a[sent];
                amt      = v_sh[sent];
                op       = v_op[sent];
                tag      = 4'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stalled)
                check_eq("stream stall hold", 64'({out_valid, sticky, tag_out, result}), 64'(held));
            if (in_valid && in_ready) begin
                exp_q.push_back({4'(sent), ref_shift(v_a[sent], v_sh[sent], v_op[sent])});
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("stream extra output", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("stream result", 64'(result), 64'(e[31:0]));
                    check_eq("stream sticky", 64'(sticky), 64'(e[32]));
                    check_eq("stream tag", 64'(tag_out), 64'(e[36:33]));
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = {out_valid, sticky, tag_out, result};
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("stream outputs", 64'(got), 64'(16));
        check_eq("stream leftover", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; sw_valid = 1'b0; out_ready = 1'b1;
        operand = '0; amt = '0; op = SHIFT_SLL; tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset out_valid", 64'(out_valid), 64'(0));
        check_eq("reset result", 64'(result), 64'(0));
        check_eq("reset sticky", 64'(sticky), 64'(0));
        check_eq("reset tag", 64'(tag_out), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("post-reset in_ready", 64'(in_ready), 64'(1));

        issue_one("sll f1<<4",     SHIFT_SLL, 32'h0000_00F1, 5'd4,  4'h1, 32'h0000_0F10, 1'b0);
        issue_one("sra >>5",       SHIFT_SRA, 32'h8000_0010, 5'd5,  4'h2, 32'hFC00_0000, 1'b1);
        issue_one("srl >>4",       SHIFT_SRL, 32'h8000_0010, 5'd4,  4'h3, 32'h0800_0001, 1'b0);
        issue_one("ror 8",         SHIFT_ROR, 32'h1234_5678, 5'd8,  4'h4, 32'h7812_3456, 1'b0);
        issue_one("ror 0",         SHIFT_ROR, 32'h1234_5678, 5'd0,  4'h5, 32'h1234_5678, 1'b0);
        issue_one("sra 0",         SHIFT_SRA, 32'h8000_0010, 5'd0,  4'h6, 32'h8000_0010, 1'b0);
        issue_one("srl 31",        SHIFT_SRL, 32'hFFFF_FFFF, 5'd31, 4'h7, 32'h0000_0001, 1'b1);
        issue_one("sll 31",        SHIFT_SLL, 32'h0000_0001, 5'd31, 4'h8, 32'h8000_0000, 1'b0);
        issue_one("sra pos 31",    SHIFT_SRA, 32'h7FFF_FFFF, 5'd31, 4'h9, 32'h0000_0000, 1'b1);
        issue_one("sll no sticky", SHIFT_SLL, 32'hFFFF_FFFF, 5'd16, 4'hA, 32'hFFFF_0000, 1'b0);

        run_stream();

        // Flush with two operations parked in the pipe behind a stalled output.
        out_ready = 1'b0;
        op = SHIFT_SLL; operand = 32'h1; amt = 5'd1; tag = 4'hC; in_valid = 1'b1;
        tick();
        tag = 4'hD;
        tick();
        tag = 4'hE; flush = 1'b1;
        #1;
        check_eq("flush in_ready", 64'(in_ready), 64'(0));
        check_eq("flush pre out_valid", 64'(out_valid), 64'(1));
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush out_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        issue_one("post-flush srl", SHIFT_SRL, 32'hF000_0000, 5'd28, 4'hF, 32'h0000_000F, 1'b0);
        for (int c = 0; c < 4; c++) begin
            check_eq("flush no ghost", 64'(out_valid), 64'(0));
            tick();
        end

        // Asynchronous reset in the middle of a stream.
        op = SHIFT_SRL; operand = 32'hFFFF_FFFF; amt = 5'd1; tag = 4'h7; in_valid = 1'b1;
        repeat (3) tick();
        check_eq("pre-reset out_valid", 64'(out_valid), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check_eq("async reset out_valid", 64'(out_valid), 64'(0));
        check_eq("async reset result", 64'(result), 64'(0));
        check_eq("async reset sticky", 64'(sticky), 64'(0));
        check_eq("async reset tag", 64'(tag_out), 64'(0));
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("release in_ready", 64'(in_ready), 64'(1));
        check_eq("release out_valid", 64'(out_valid), 64'(0));
        tick();
        check_eq("release out_valid later", 64'(out_valid), 64'(0));

        sweep_one("sweep sra", SHIFT_SRA, 32'h8000_0010, 5'd5,  32'hFC00_0000, 1'b1);
        sweep_one("sweep ror", SHIFT_ROR, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0);
        sweep_one("sweep srl", SHIFT_SRL, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
